// File: rtl/regfile_read_port.sv
// regfile_read_port: 32-entry register array with one write port and two
// operand read ports. Reads are served through a registered valid/ready
// request/response stage with a latency of one cycle.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN forwards same-cycle write
// data into a response whose read address matches the write row.

module regfile_read_port #(
    parameter int DATA_WIDTH = 64,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WriteEnable,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZeroAddr = 5'(ZERO_REG);

    typedef enum logic {
        Empty = 1'b0,
        Full  = 1'b1
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] readData1_q;
    logic [DATA_WIDTH-1:0] readData2_q;
    logic [DATA_WIDTH-1:0] readData1_d;
    logic [DATA_WIDTH-1:0] readData2_d;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic [31:0]           rowWriteEn;
    logic                  reqFire;

    assign resp_valid = (state_q == Full);
    assign req_ready  = !resp_valid || resp_ready;
    assign reqFire    = req_valid && req_ready;
    assign ReadData1  = readData1_q;
    assign ReadData2  = readData2_q;

    // One-hot row write enables; the hardwired-zero row never gets one.
    always_comb begin
        rowWriteEn = '0;
        if (WriteEnable && (WriteRegister != ZeroAddr)) begin
            rowWriteEn[WriteRegister] = 1'b1;
        end
    end

    // Register array: cleared on reset, each row loads write data when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (rowWriteEn[i]) begin
                    regs_q[i] <= WriteData;
                end
            end
        end
    end

    // Operand selection, optional write forwarding, zero-register override last.
    always_comb begin
        operand1 = regs_q[ReadRegister1];
        operand2 = regs_q[ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (WriteEnable && (WriteRegister == ReadRegister1)) begin
            operand1 = WriteData;
        end
        if (WriteEnable && (WriteRegister == ReadRegister2)) begin
            operand2 = WriteData;
        end
`endif
        if (ReadRegister1 == ZeroAddr) begin
            operand1 = '0;
        end
        if (ReadRegister2 == ZeroAddr) begin
            operand2 = '0;
        end
    end

    // Response data loads only on a request handshake and otherwise holds.
    always_comb begin
        readData1_d = readData1_q;
        readData2_d = readData2_q;
        if (reqFire) begin
            readData1_d = operand1;
            readData2_d = operand2;
        end
    end

    // Two-state output stage controller with registered response data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= Empty;
            readData1_q <= '0;
            readData2_q <= '0;
        end else begin
            readData1_q <= readData1_d;
            readData2_q <= readData2_d;
            case (state_q)
                Empty: begin
                    if (reqFire) begin
                        state_q <= Full;
                    end
                end
                Full: begin
                    if (resp_ready && !reqFire) begin
                        state_q <= Empty;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed stimulus with a response scoreboard. The
// stimulus process queues the expected operand pair for every request that
// will be consumed; the monitor pops and compares on each consumed response.

module tb_regfile_read_port;

    localparam int DW = 64;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } resp_t;

    logic          clk;
    logic          reset;
    logic          WriteEnable;
    logic [4:0]    WriteRegister;
    logic [DW-1:0] WriteData;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    int    checks   = 0;
    int    failures = 0;
    resp_t expQ[$];

    regfile_read_port #(.DATA_WIDTH(DW), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .WriteEnable   (WriteEnable),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [DW-1:0] wd,
                                 input logic rv, input logic [4:0] r1, input logic [4:0] r2);
        WriteEnable   = we;
        WriteRegister = wr;
        WriteData     = wd;
        req_valid     = rv;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    task automatic writeReg(input logic [4:0] wr, input logic [DW-1:0] wd);
        applyStimulus(1'b1, wr, wd, 1'b0, 5'd0, 5'd0);
        tick();
        WriteEnable = 1'b0;
    endtask

    task automatic pushExp(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        resp_t e;
        e.d1 = d1;
        e.d2 = d2;
        expQ.push_back(e);
    endtask

    // Monitor: every response consumed by the execute stage is scored.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_response: got 0x%0h/0x%0h, expected none",
                         ReadData1, ReadData2);
            end else begin
                resp_t e;
                e = expQ.pop_front();
                checkOutput("resp_ReadData1", ReadData1, e.d1);
                checkOutput("resp_ReadData2", ReadData2, e.d2);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [DW-1:0] r9Expected;
    logic [DW-1:0] streamVals [1:4];

    initial begin
        reset      = 1'b1;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        #3;
        checkOutput("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        checkOutput("reset_ReadData1", ReadData1, 64'd0);
        checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset while a response is stalled.
        writeReg(5'd5, 64'h1234);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 5'd5);
        tick();
        req_valid = 1'b0;
        checkOutput("stall_pre_reset_valid", {63'd0, resp_valid}, 64'd1);
        checkOutput("stall_pre_reset_data", ReadData1, 64'h1234);
        tick();
        checkOutput("stall_pre_reset_req_ready", {63'd0, req_ready}, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        checkOutput("async_reset_ReadData1", ReadData1, 64'd0);
        tick();
        reset      = 1'b0;
        resp_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 5'd5);
        pushExp(64'd0, 64'd0);
        tick();
        req_valid = 1'b0;
        tick();

        // Basic two-operand read.
        writeReg(5'd3, 64'hAAAA);
        writeReg(5'd7, 64'h5555);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd7);
        pushExp(64'hAAAA, 64'h5555);
        tick();
        req_valid = 1'b0;
        checkOutput("basic_latency_valid", {63'd0, resp_valid}, 64'd1);
        tick();

        // Zero register ignores writes and always reads zero.
        writeReg(5'd31, 64'hFFFF);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd31, 5'd31);
        pushExp(64'd0, 64'd0);
        tick();
        req_valid = 1'b0;
        tick();

        // Stall hold with a write to the held row.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd3);
        pushExp(64'hAAAA, 64'hAAAA);
        tick();
        applyStimulus(1'b1, 5'd3, 64'hBEEF, 1'b0, 5'd3, 5'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_req_ready", {63'd0, req_ready}, 64'd0);
            checkOutput("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
            checkOutput("stall_hold_ReadData1", ReadData1, 64'hAAAA);
            checkOutput("stall_hold_ReadData2", ReadData2, 64'hAAAA);
            tick();
        end
        WriteEnable = 1'b0;
        resp_ready  = 1'b1;
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0);
        pushExp(64'hBEEF, 64'd0);
        tick();
        req_valid = 1'b0;
        tick();

        // Streaming, one request per cycle.
        streamVals[1] = 64'h11;
        streamVals[2] = 64'h22;
        streamVals[3] = 64'hBEEF;
        streamVals[4] = 64'h44;
        writeReg(5'd1, streamVals[1]);
        writeReg(5'd2, streamVals[2]);
        writeReg(5'd4, streamVals[4]);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'(i), 5'd0);
            pushExp(streamVals[i], 64'd0);
            tick();
            checkOutput("stream_no_bubble", {63'd0, resp_valid}, 64'd1);
        end
        req_valid = 1'b0;
        tick();

        // Same-cycle write and read of one row.
        writeReg(5'd9, 64'h10);
`ifdef REGFILE_WRITE_BYPASS_EN
        r9Expected = 64'h77;
`else
        r9Expected = 64'h10;
`endif
        applyStimulus(1'b1, 5'd9, 64'h77, 1'b1, 5'd9, 5'd9);
        pushExp(r9Expected, r9Expected);
        tick();
        // Zero register stays zero even when written in the request cycle.
        applyStimulus(1'b1, 5'd31, 64'hFF, 1'b1, 5'd31, 5'd9);
        pushExp(64'd0, 64'h77);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        tick();

        // Drain: wait for all expected responses, bounded.
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            tick();
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending responses, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
